// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode encodings, select codes and per-stage control bundles
// for the pipelined control unit.
package pipe_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b000001;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   // Controls consumed in EX only
   typedef struct packed {
      logic [1:0] aluop;
      logic       alusrc;
      logic       branch;
      logic       bne;
   } ex_ctrl_t;

   // Controls consumed in MEM
   typedef struct packed {
      logic memread;
      logic memwrite;
   } mem_ctrl_t;

   // Controls consumed in WB
   typedef struct packed {
      logic regwrite;
      logic memtoreg;
   } wb_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_unit_fwd.sv
// EX-stage operand forwarding selects, computed from the downstream
// stage registers. Dest 0 never matches because its regwrite is
// already suppressed at decode.
module pipe_fwd_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int FWD_EN = 1
) (
   input  logic [REG_AW-1:0] i_ex_rs,
   input  logic [REG_AW-1:0] i_ex_rt,
   input  logic              i_exmem_regwrite,
   input  logic [REG_AW-1:0] i_exmem_dest,
   input  logic              i_memwb_regwrite,
   input  logic [REG_AW-1:0] i_memwb_dest,
   output logic [1:0]        o_fwd_a,
   output logic [1:0]        o_fwd_b
);

   // Pick the youngest producer per operand; EX/MEM beats MEM/WB.
   always_comb begin
      o_fwd_a = FWD_REG;
      o_fwd_b = FWD_REG;
      if (FWD_EN != 0) begin
         if (i_exmem_regwrite && (i_exmem_dest == i_ex_rs))      o_fwd_a = FWD_EXMEM;
         else if (i_memwb_regwrite && (i_memwb_dest == i_ex_rs)) o_fwd_a = FWD_MEMWB;
         if (i_exmem_regwrite && (i_exmem_dest == i_ex_rt))      o_fwd_b = FWD_EXMEM;
         else if (i_memwb_regwrite && (i_memwb_dest == i_ex_rt)) o_fwd_b = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID opcode, carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, and resolves load-use
// stalls, branch/jump flushes and EX forwarding selects.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int OPC_W  = 6,
   parameter int REG_AW = 5,
   parameter int FWD_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              id_valid,
   input  logic [OPC_W-1:0]  id_opcode,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              ex_branch_taken,
   output logic              stall_if,
   output logic              flush_if_id,
   output logic              id_illegal,
   output logic [1:0]        ex_aluop,
   output logic              ex_alusrc,
   output logic              ex_branch,
   output logic              ex_bne,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic              mem_read,
   output logic              mem_write,
   output logic              wb_regwrite,
   output logic              wb_memtoreg,
   output logic [REG_AW-1:0] wb_dest,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
);

   // ID decode results
   ex_ctrl_t          w_ex;
   mem_ctrl_t         w_mem;
   wb_ctrl_t          w_wb;
   logic              w_regdst, w_jump, w_uses_rt, w_known;
   logic [REG_AW-1:0] w_dest;
   logic              w_hit_idex, w_hit_exmem, w_hazard, w_illegal, w_bubble;

   // Stage registers
   ex_ctrl_t          r_idex_ex;
   mem_ctrl_t         r_idex_mem;
   wb_ctrl_t          r_idex_wb;
   logic [REG_AW-1:0] r_idex_dest, r_ex_rs, r_ex_rt;
   mem_ctrl_t         r_exmem_mem;
   wb_ctrl_t          r_exmem_wb;
   logic [REG_AW-1:0] r_exmem_dest;
   wb_ctrl_t          r_memwb_wb;
   logic [REG_AW-1:0] r_memwb_dest;

   // Opcode decode; undefined opcodes leave every control at 0.
   always_comb begin
      w_ex      = '0;
      w_mem     = '0;
      w_wb      = '0;
      w_regdst  = 1'b0;
      w_jump    = 1'b0;
      w_uses_rt = 1'b0;
      w_known   = 1'b1;
      case (id_opcode)
         OPC_W'(OP_RTYPE): begin
            w_regdst = 1'b1; w_ex.aluop = ALUOP_FUNCT; w_wb.regwrite = 1'b1; w_uses_rt = 1'b1;
         end
         OPC_W'(OP_LW): begin
            w_ex.alusrc = 1'b1; w_mem.memread = 1'b1; w_wb.memtoreg = 1'b1; w_wb.regwrite = 1'b1;
         end
         OPC_W'(OP_SW): begin
            w_ex.alusrc = 1'b1; w_mem.memwrite = 1'b1; w_uses_rt = 1'b1;
         end
         OPC_W'(OP_BEQ): begin
            w_ex.branch = 1'b1; w_ex.aluop = ALUOP_SUB; w_uses_rt = 1'b1;
         end
         OPC_W'(OP_BNE): begin
            w_ex.branch = 1'b1; w_ex.bne = 1'b1; w_ex.aluop = ALUOP_SUB; w_uses_rt = 1'b1;
         end
         OPC_W'(OP_J):    w_jump = 1'b1;
         OPC_W'(OP_ADDI): begin
            w_ex.alusrc = 1'b1; w_wb.regwrite = 1'b1;
         end
         default: w_known = 1'b0;
      endcase
      w_dest = w_regdst ? id_rd : id_rt;
      if (w_dest == '0) w_wb.regwrite = 1'b0;
   end

   assign w_hit_idex  = (r_idex_dest == id_rs)  | (w_uses_rt & (r_idex_dest == id_rt));
   assign w_hit_exmem = (r_exmem_dest == id_rs) | (w_uses_rt & (r_exmem_dest == id_rt));

   // Without forwarding, any pending write in EX or MEM must drain first.
   assign w_hazard = (FWD_EN != 0)
      ? (id_valid & r_idex_mem.memread & (r_idex_dest != '0) & w_hit_idex)
      : (id_valid & ((r_idex_wb.regwrite & w_hit_idex) | (r_exmem_wb.regwrite & w_hit_exmem)));

   assign w_illegal   = id_valid & ~w_known;
   assign w_bubble    = ~id_valid | w_hazard | ex_branch_taken | w_illegal;

   assign id_illegal  = w_illegal & ~rst;
   assign stall_if    = ~rst & w_hazard & ~ex_branch_taken & ~hold;
   assign flush_if_id = ~rst & ~hold & (ex_branch_taken | (id_valid & w_jump & ~w_hazard));

   // ID/EX: load the decoded bundle or insert a bubble; freeze on hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idex_ex   <= '0;
         r_idex_mem  <= '0;
         r_idex_wb   <= '0;
         r_idex_dest <= '0;
         r_ex_rs     <= '0;
         r_ex_rt     <= '0;
      end else if (!hold) begin
         if (w_bubble) begin
            r_idex_ex   <= '0;
            r_idex_mem  <= '0;
            r_idex_wb   <= '0;
            r_idex_dest <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
         end else begin
            r_idex_ex   <= w_ex;
            r_idex_mem  <= w_mem;
            r_idex_wb   <= w_wb;
            r_idex_dest <= w_dest;
            r_ex_rs     <= id_rs;
            r_ex_rt     <= id_rt;
         end
      end
   end

   // EX/MEM and MEM/WB shift on every non-hold edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exmem_mem  <= '0;
         r_exmem_wb   <= '0;
         r_exmem_dest <= '0;
         r_memwb_wb   <= '0;
         r_memwb_dest <= '0;
      end else if (!hold) begin
         r_exmem_mem  <= r_idex_mem;
         r_exmem_wb   <= r_idex_wb;
         r_exmem_dest <= r_idex_dest;
         r_memwb_wb   <= r_exmem_wb;
         r_memwb_dest <= r_exmem_dest;
      end
   end

   pipe_fwd_unit #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd (
      .i_ex_rs          (r_ex_rs),
      .i_ex_rt          (r_ex_rt),
      .i_exmem_regwrite (r_exmem_wb.regwrite),
      .i_exmem_dest     (r_exmem_dest),
      .i_memwb_regwrite (r_memwb_wb.regwrite),
      .i_memwb_dest     (r_memwb_dest),
      .o_fwd_a          (fwd_a),
      .o_fwd_b          (fwd_b)
   );

   assign ex_aluop    = r_idex_ex.aluop;
   assign ex_alusrc   = r_idex_ex.alusrc;
   assign ex_branch   = r_idex_ex.branch;
   assign ex_bne      = r_idex_ex.bne;
   assign ex_rs       = r_ex_rs;
   assign ex_rt       = r_ex_rt;
   assign mem_read    = r_exmem_mem.memread;
   assign mem_write   = r_exmem_mem.memwrite;
   assign wb_regwrite = r_memwb_wb.regwrite;
   assign wb_memtoreg = r_memwb_wb.memtoreg;
   assign wb_dest     = r_memwb_dest;

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Pipelined successor to the single-cycle main decoder. It decodes the ID-stage opcode into a control bundle and carries that bundle through its own ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards, handles branch and jump flushes, and generates EX-stage forwarding selects. The datapath pipeline registers stay outside; this block owns only control state.

Parameters:
OPC_W, 6, opcode field width
REG_AW, 5, register address width
FWD_EN, 1, 1 = forwarding selects active; 0 = fwd_a/fwd_b tied 00 and load-use check widened to any RAW hazard on EX/MEM/ID-EX dest

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
hold  in  1  global freeze (memory wait); all control state holds
id_valid  in  1  IF/ID holds a real instruction
id_opcode  in  OPC_W  opcode of ID instruction
id_rs  in  REG_AW  source A address
id_rt  in  REG_AW  source B / I-type dest address
id_rd  in  REG_AW  R-type dest address
ex_branch_taken  in  1  EX-stage branch resolved taken (comparator result qualified by ex_branch/ex_bne)
stall_if  out  1  hold PC and IF/ID this cycle
flush_if_id  out  1  invalidate IF/ID at next edge
id_illegal  out  1  ID holds a valid but undefined opcode (combinational pulse)
ex_aluop  out  2  ALU op class: 00 add, 01 sub/compare, 10 funct
ex_alusrc  out  1  ALU B = immediate
ex_branch  out  1  BEQ in EX
ex_bne  out  1  BNE in EX
ex_rs  out  REG_AW  EX source A address
ex_rt  out  REG_AW  EX source B address
mem_read  out  1  load in MEM
mem_write  out  1  store in MEM
wb_regwrite  out  1  register-file write enable in WB
wb_memtoreg  out  1  WB selects memory data
wb_dest  out  REG_AW  WB destination
fwd_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  out  2  EX operand B select, same encoding

Behaviour:
- Decode is combinational in ID. Opcodes are fixed:
  - R 000000: regdst=1, aluop 10, regwrite.
  - LW 100011: alusrc, memread, memtoreg, regwrite.
  - SW 101011: alusrc, memwrite.
  - BEQ 000100: branch, aluop 01.
  - BNE 000101: branch, bne, aluop 01.
  - J 000010: jump.
  - ADDI 000001: alusrc, regwrite.
  - Any other opcode: all controls 0; id_illegal = id_valid.
- Dest resolved in ID: rd if regdst, else rt. regwrite is forced 0 when dest == 0.
- uses_rt is true for R, SW, BEQ, BNE.
- Load-use hazard: id_valid & idex_memread & idex_dest != 0 & (idex_dest == id_rs | (uses_rt & idex_dest == id_rt)).
- stall_if = hazard & ~ex_branch_taken & ~hold.
- flush_if_id = ~hold & (ex_branch_taken | (id_valid & jump & ~hazard)).
- Jump costs 1 cycle; taken branch costs 2 cycles (IF/ID flushed and ID/EX bubbled).
- ID/EX update priority, at each edge:
  1. rst: all control registers cleared.
  2. hold: all stages keep their value.
  3. ~id_valid | hazard | ex_branch_taken | id_illegal: bubble (all controls 0).
  4. Otherwise: load the decoded bundle.
- EX/MEM and MEM/WB shift every non-hold cycle and carry memread/memwrite/memtoreg/regwrite/dest.
- Latency: ID to ex_* = 1 cycle, to mem_* = 2, to wb_* = 3.
- Forwarding is combinational from the stage registers:
  - fwd_a = 10 if exmem_regwrite & exmem_dest == ex_rs.
  - Else 01 if memwb_regwrite & memwb_dest == ex_rs.
  - Else 00. fwd_b uses ex_rt with the same rules.
  - EX/MEM has priority over MEM/WB.
  - Dest 0 never matches, because regwrite is suppressed.
- Reset value of every output is 0. stall_if and flush_if_id are 0 while rst is high.
- hold together with ex_branch_taken: nothing changes. EX keeps asserting ex_branch_taken because its state is frozen, and the flush happens on the first non-hold edge.
- Reset mid-operation: all in-flight instructions are discarded with no writeback. Any WB asserted before rst rose is not replayed.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI);
  - ALUOP_ADD/SUB/FUNCT;
  - FWD_REG/EXMEM/MEMWB;
  - packed struct types ex_ctrl_t, mem_ctrl_t, wb_ctrl_t.
- One sub-module, pipe_fwd_unit: combinational forwarding-select logic, instantiated once.

Test Plan:
- Reset: hold rst for 2 cycles with a valid LW in ID -> every output 0. First decode appears 1 cycle after rst falls.
- R-type rd=3 -> next cycle ex_aluop=10, ex_alusrc=0. Three cycles after ID: wb_regwrite=1, wb_dest=3, wb_memtoreg=0.
- LW rt=5, then R-type rs=5 -> stall_if=1 for exactly 1 cycle and a bubble in EX. When the R-type reaches EX, fwd_a=01.
- ADDI rt=4, then SW rt=4 -> fwd_b=10 when the SW is in EX, with no stall. ADDI with rt=0 -> wb_regwrite stays 0.
- BEQ in EX with ex_branch_taken=1 -> flush_if_id=1 and the next EX is a bubble. J in ID -> flush_if_id=1 in the same cycle, and the jump produces no regwrite.
- Simultaneous events and illegal opcode:
  - hold=1 with ex_branch_taken=1 for 3 cycles -> flush_if_id=0 and stage outputs frozen. Releasing hold -> flush on the next edge.
  - Opcode 111111 valid -> id_illegal=1 and a bubble issues.
